// File: rtl/clk_div_mon.sv
// Monitor for a clock divider output: edge strobes, period/high-time measurement,
// lock detection against the programmed divide value, and a sticky error flag.
module clk_div_mon #(
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [DW-1:0] div,
  input  logic          clk_div,
  input  logic          clr_err,
  output logic          rise_stb,
  output logic          fall_stb,
  output logic [DW-1:0] period,
  output logic [DW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          err
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StIdle, StMeas, StLocked} state_e;

  state_e        state_q, state_d;
  logic          s0_q, s1_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hcnt_q, hcnt_d;
  logic          fell_q, fell_d;
  logic [DW-1:0] div_q;
  logic [DW-1:0] period_q, period_d;
  logic [DW-1:0] high_q, high_d;
  logic          mv_q, mv_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [MW-1:0] match_q, match_d;

  logic [DW:0]   exp_p;
  logic [DW-1:0] meas_h;
  logic          chk_en, div_chg, match, timeout, err_evt;

  assign rise_stb   = s0_q & ~s1_q;
  assign fall_stb   = ~s0_q & s1_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign err        = err_q;

  assign exp_p   = {1'b0, div_q} << 1;
  assign chk_en  = (div_q != '0);
  assign div_chg = (div != div_q);
  // A rise without an intervening fall has no valid high time.
  assign meas_h  = fell_q ? hcnt_q : '0;
  assign match   = ({1'b0, cnt_q} == exp_p) && (meas_h == div_q);
  assign timeout = chk_en && !rise_stb && ({1'b0, cnt_q} > exp_p);

  always_comb begin
    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    hcnt_d = hcnt_q;
    fell_d = fell_q;
    if (rise_stb) begin
      cnt_d  = {{(DW-1){1'b0}}, 1'b1};
      fell_d = 1'b0;
    end else if (fall_stb) begin
      hcnt_d = cnt_q;
      fell_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    locked_d = locked_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    err_evt  = 1'b0;
    if (div_chg) begin
      // New divide value: drop the partial measurement and start over.
      state_d  = StIdle;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise_stb) state_d = StMeas;
        end
        StMeas, StLocked: begin
          if (rise_stb) begin
            period_d = cnt_q;
            high_d   = meas_h;
            mv_d     = 1'b1;
            if (chk_en) begin
              if (!match) begin
                err_evt  = 1'b1;
                match_d  = '0;
                locked_d = 1'b0;
                state_d  = StMeas;
              end else if (state_q == StMeas) begin
                match_d = match_q + 1'b1;
                if (match_q == MW'(LOCK_CNT - 1)) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
                end
              end
            end
          end else if (timeout) begin
            err_evt  = 1'b1;
            match_d  = '0;
            locked_d = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_err) err_d = 1'b0;
    if (err_evt) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      fell_q   <= 1'b0;
      div_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      s0_q     <= clk_div;
      s1_q     <= s0_q;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      fell_q   <= fell_d;
      div_q    <= div;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

endmodule

// File: tb/tb_clk_div_mon.sv
// Scoreboard bench for clk_div_mon: stimulus pushes expected measurements, a forked
// monitor pops and compares them whenever meas_valid pulses.
module tb_clk_div_mon;

  logic        clk;
  logic        nrst;
  logic [31:0] div;
  logic        clk_div;
  logic        clr_err;
  logic        rise_stb;
  logic        fall_stb;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        meas_valid;
  logic        locked;
  logic        err;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic        l;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   n_rise_exp;
  int   n_rise_seen;

  clk_div_mon #(
    .DW      (32),
    .LOCK_CNT(4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .div       (div),
    .clk_div   (clk_div),
    .clr_err   (clr_err),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push(input int p, input int h, input bit l, input bit e);
    exp_t x;
    x.p = p;
    x.h = h;
    x.l = l;
    x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clk_div period: hi cycles high then lo cycles low; clr_err pulsed at index clr_at.
  task automatic wave(input int hi, input int lo, input int clr_at = -1);
    n_rise_exp++;
    for (int i = 0; i < hi + lo; i++) begin
      clk_div = (i < hi);
      clr_err = (i == clr_at);
      step();
    end
    clr_err = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (nrst && rise_stb) n_rise_seen++;
      if (meas_valid) begin
        g = {period, high_time, locked, err};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL meas_unexpected: got p=%0d h=%0d l=%0b e=%0b, expected none",
                   period, high_time, locked, err);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (g !== e) begin
            n_fail++;
            $display("FAIL meas: got p=%0d h=%0d l=%0b e=%0b, expected p=%0d h=%0d l=%0b e=%0b",
                     period, high_time, locked, err, e.p, e.h, e.l, e.e);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_rise_exp  = 0;
    n_rise_seen = 0;
    nrst        = 1'b0;
    div         = 32'd1;
    clk_div     = 1'b0;
    clr_err     = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    step();
    step();
    check("rst_period", 64'(period), 64'd0);
    check("rst_high", 64'(high_time), 64'd0);
    check("rst_flags", 64'({meas_valid, locked, err, rise_stb, fall_stb}), 64'd0);
    nrst = 1'b1;
    repeat (3) step();

    // div=1: period 2, high 1, lock on 4th measurement
    wave(1, 1);
    for (int i = 0; i < 5; i++) begin
      push(2, 1, i >= 3, 0);
      wave(1, 1);
    end
    check("a_locked", 64'(locked), 64'd1);
    check("a_err", 64'(err), 64'd0);

    // div 1->2 while locked: lock drops next cycle, no error, relock at 4/2
    div = 32'd2;
    check("b_locked_hold", 64'(locked), 64'd1);
    step();
    check("b_locked_drop", 64'(locked), 64'd0);
    check("b_err", 64'(err), 64'd0);
    step();
    wave(2, 2);
    for (int i = 0; i < 5; i++) begin
      push(4, 2, i >= 3, 0);
      wave(2, 2);
    end
    check("b_relock", 64'(locked), 64'd1);

    // div=3: stuck-low clk_div times out when cnt reaches 7
    div = 32'd3;
    step();
    step();
    wave(3, 3);
    push(6, 3, 0, 0);
    wave(3, 3);
    push(6, 3, 0, 0);
    n_rise_exp++;
    clk_div = 1'b1;
    repeat (3) step();
    clk_div = 1'b0;
    repeat (5) step();
    check("c_err_before_to", 64'(err), 64'd0);
    step();
    check("c_err_timeout", 64'(err), 64'd1);
    check("c_locked", 64'(locked), 64'd0);
    repeat (4) step();

    // div=4: clear, lock, long period (times out), relock, mismatch, clear collisions
    div = 32'd4;
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("d_clr", 64'(err), 64'd0);
    step();
    wave(4, 4);
    for (int i = 0; i < 4; i++) begin
      push(8, 4, i == 3, 0);
      wave(4, 4);
    end
    push(8, 4, 1, 0);
    wave(5, 5);
    wave(4, 4);
    check("d_err_long", 64'(err), 64'd1);
    check("d_unlock_long", 64'(locked), 64'd0);
    for (int i = 0; i < 4; i++) begin
      push(8, 4, i == 3, 1);
      wave(4, 4);
    end
    check("d_relock", 64'(locked), 64'd1);
    push(8, 4, 1, 1);
    wave(3, 1);
    push(4, 3, 0, 1);
    wave(4, 4, 1);
    check("d_err_wins_clr", 64'(err), 64'd1);
    check("d_unlock_mismatch", 64'(locked), 64'd0);
    push(8, 4, 0, 0);
    wave(4, 4, 0);
    check("d_err_cleared", 64'(err), 64'd0);

    // div=0: measurement without checking
    div = 32'd0;
    step();
    wave(3, 2);
    push(5, 3, 0, 0);
    wave(3, 2);
    push(5, 3, 0, 0);
    wave(1, 6);
    push(7, 1, 0, 0);
    wave(3, 2);
    push(5, 3, 0, 0);
    wave(3, 2);
    check("e_locked", 64'(locked), 64'd0);
    check("e_err", 64'(err), 64'd0);

    // div=2: lock, then asynchronous reset mid-operation
    div = 32'd2;
    step();
    wave(2, 2);
    for (int i = 0; i < 4; i++) begin
      push(4, 2, i == 3, 0);
      wave(2, 2);
    end
    check("f_locked", 64'(locked), 64'd1);
    clk_div = 1'b1;
    step();
    nrst    = 1'b0;
    clk_div = 1'b0;
    #1;
    check("f_rst_period", 64'(period), 64'd0);
    check("f_rst_high", 64'(high_time), 64'd0);
    check("f_rst_flags", 64'({meas_valid, locked, err, rise_stb, fall_stb}), 64'd0);
    step();
    step();
    nrst = 1'b1;
    step();
    step();
    wave(2, 2);
    for (int i = 0; i < 5; i++) begin
      push(4, 2, i >= 3, 0);
      wave(2, 2);
    end
    check("g_relock", 64'(locked), 64'd1);
    check("g_err", 64'(err), 64'd0);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("rise_count", 64'(n_rise_seen), 64'(n_rise_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
